// File: rtl/eth_mac_tx_ptp_tagger.sv
// Tags outgoing TX frames with a rolling PTP tag and matches returning MAC timestamps against the outstanding tags.
// Define ETH_MAC_TX_PTP_TAGGER_TIMEOUT_EN to discard head tags whose timestamp never returns.
module eth_mac_tx_ptp_tagger #(
    parameter int DATA_WIDTH   = 64,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int TAG_WIDTH    = 16,
    parameter int PTP_TS_WIDTH = 96,
    parameter int PEND_DEPTH   = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [TAG_WIDTH:0]            m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic [PTP_TS_WIDTH-1:0]       s_ts,
    input  logic [TAG_WIDTH-1:0]          s_ts_tag,
    input  logic                          s_ts_valid,
    output logic [PTP_TS_WIDTH-1:0]       m_ts,
    output logic [TAG_WIDTH-1:0]          m_ts_tag,
    output logic                          m_ts_valid,
    input  logic                          m_ts_ready,
    output logic [$clog2(PEND_DEPTH):0]   pend_count,
    output logic                          stat_lost,
    output logic                          stat_unexp
);

    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t               state;
    logic [TAG_WIDTH-1:0] tag_cnt;
    logic [TAG_WIDTH-1:0] frame_tag;
    logic [TAG_WIDTH-1:0] beat_tag;

    logic [TAG_WIDTH-1:0] fifo_mem [PEND_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [TAG_WIDTH-1:0] head_tag;
    logic                 fifo_empty;
    logic                 fifo_full;

    logic stage_free;
    logic beat_accept;
    logic push;
    logic pop;
    logic ts_match;
    logic ts_out_free;
    logic timeout_pop;

    assign stage_free  = m_axis_tready || !m_axis_tvalid;
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_W'(PEND_DEPTH));
    assign head_tag    = fifo_mem[rd_ptr];

    // A full FIFO only blocks the start of a frame; beats inside a frame always flow.
    assign s_axis_tready = !rst && stage_free && ((state == FRAME) || !fifo_full);
    assign beat_accept   = s_axis_tvalid && s_axis_tready;
    assign push          = beat_accept && (state == IDLE);
    assign beat_tag      = (state == IDLE) ? tag_cnt : frame_tag;

    assign ts_match    = s_ts_valid && !fifo_empty && (s_ts_tag == head_tag);
    assign ts_out_free = !m_ts_valid || m_ts_ready;
    assign pop         = ts_match || timeout_pop;
    assign pend_count  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (stage_free) begin
                m_axis_tvalid <= beat_accept;
            end
            if (beat_accept) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tkeep <= s_axis_tkeep;
                m_axis_tlast <= s_axis_tlast;
                m_axis_tuser <= {beat_tag, s_axis_tuser};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tag_cnt   <= '0;
            frame_tag <= '0;
        end else if (beat_accept) begin
            case (state)
                IDLE: begin
                    frame_tag <= tag_cnt;
                    tag_cnt   <= tag_cnt + 1'b1;
                    if (!s_axis_tlast) begin
                        state <= FRAME;
                    end
                end
                FRAME: begin
                    if (s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tag_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A matched tag is popped even when the output is busy, so the FIFO never stalls on a slow consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_ts       <= '0;
            m_ts_tag   <= '0;
            m_ts_valid <= 1'b0;
            stat_unexp <= 1'b0;
        end else begin
            stat_unexp <= s_ts_valid && !(ts_match && ts_out_free);
            if (m_ts_valid && m_ts_ready) begin
                m_ts_valid <= 1'b0;
            end
            if (ts_match && ts_out_free) begin
                m_ts       <= s_ts;
                m_ts_tag   <= s_ts_tag;
                m_ts_valid <= 1'b1;
            end
        end
    end

`ifdef ETH_MAC_TX_PTP_TAGGER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign timeout_pop = !fifo_empty && !ts_match && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Held at zero while empty, so a fresh head always starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            stat_lost <= 1'b0;
        end else begin
            stat_lost <= timeout_pop;
            if (pop || fifo_empty) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_pop    = 1'b0;
    assign stat_lost      = 1'b0;
`endif

endmodule

// File: tb/tb_eth_mac_tx_ptp_tagger.sv
// Directed bench for eth_mac_tx_ptp_tagger: tagging, matching, FIFO full stall, tag wrap and timeout behaviour.
module tb_eth_mac_tx_ptp_tagger;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int TW = 16;
    localparam int SW = 96;
    localparam int PD = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [TW:0]   m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [SW-1:0] s_ts;
    logic [TW-1:0] s_ts_tag;
    logic          s_ts_valid;
    logic [SW-1:0] m_ts;
    logic [TW-1:0] m_ts_tag;
    logic          m_ts_valid;
    logic          m_ts_ready;
    logic [3:0]    pend_count;
    logic          stat_lost;
    logic          stat_unexp;

    int n_vec = 0;
    int n_err = 0;

    eth_mac_tx_ptp_tagger #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TAG_WIDTH(TW),
        .PTP_TS_WIDTH(SW), .PEND_DEPTH(PD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_ts(s_ts), .s_ts_tag(s_ts_tag), .s_ts_valid(s_ts_valid),
        .m_ts(m_ts), .m_ts_tag(m_ts_tag), .m_ts_valid(m_ts_valid), .m_ts_ready(m_ts_ready),
        .pend_count(pend_count), .stat_lost(stat_lost), .stat_unexp(stat_unexp)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_ts          = '0;
        s_ts_tag      = '0;
        s_ts_valid    = 1'b0;
        m_axis_tready = 1'b1;
        m_ts_ready    = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic single_frame(input logic [DW-1:0] data);
        s_axis_tdata  = data;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tuser, m_ts_valid, pend_count, stat_lost, stat_unexp} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b tvalid=%b tuser=%h tsv=%b pend=%0d lost=%b unexp=%b, all required 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tuser, m_ts_valid, pend_count, stat_lost, stat_unexp);
        end
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        n_vec++;
        if (s_axis_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_after: got %b need 1", s_axis_tready);
        end
    endtask

    task automatic test_tagging();
        int sizes [3] = '{1, 9, 64};
        int nbeats, rem;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
        logic          err;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            nbeats = (sizes[f] + 7) / 8;
            for (int b = 0; b < nbeats; b++) begin
                rem  = sizes[f] - 8 * b;
                keep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
                data = {32'hC0DE_0000 + 32'(f), 32'(b * 7 + 3)};
                err  = (f == 1);
                s_axis_tdata  = data;
                s_axis_tkeep  = keep;
                s_axis_tlast  = (b == nbeats - 1);
                s_axis_tuser  = err;
                s_axis_tvalid = 1'b1;
                #1;
                n_vec++;
                if (s_axis_tready !== 1'b1) begin
                    n_err++;
                    $display("FAIL tag_ready f%0d b%0d: got %b need 1", f, b, s_axis_tready);
                end
                @(posedge clk); #1;
                n_vec++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== data || m_axis_tkeep !== keep ||
                    m_axis_tlast !== (b == nbeats - 1) || m_axis_tuser !== {16'(f), err}) begin
                    n_err++;
                    $display("FAIL tag_beat f%0d b%0d: v=%b d=%h k=%h l=%b u=%h need v=1 d=%h k=%h l=%b u=%h",
                             f, b, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                             data, keep, (b == nbeats - 1), {16'(f), err});
                end
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        n_vec++;
        if (pend_count !== 4'd3 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL tag_pend: pend=%0d tvalid=%b need pend=3 tvalid=0", pend_count, m_axis_tvalid);
        end
    endtask

    task automatic test_match();
        for (int i = 0; i < 3; i++) begin
            s_ts_valid = 1'b1;
            s_ts_tag   = 16'(i);
            s_ts       = 96'(16 * (i + 1));
            @(posedge clk); #1;
            s_ts_valid = 1'b0;
            n_vec++;
            if (m_ts_valid !== 1'b1 || m_ts !== 96'(16 * (i + 1)) || m_ts_tag !== 16'(i) || stat_unexp !== 1'b0) begin
                n_err++;
                $display("FAIL match_%0d: v=%b ts=%h tag=%0d unexp=%b need v=1 ts=%h tag=%0d unexp=0",
                         i, m_ts_valid, m_ts, m_ts_tag, stat_unexp, 96'(16 * (i + 1)), i);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (pend_count !== 4'd0 || m_ts_valid !== 1'b0) begin
            n_err++;
            $display("FAIL match_drain: pend=%0d tsv=%b need 0 0", pend_count, m_ts_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_axis_tready = 1'b0;
        s_axis_tdata  = 64'hAAAA_0001;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        #1;
        n_vec++;
        if (s_axis_tready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first_ready: got %b need 1", s_axis_tready);
        end
        @(posedge clk); #1;
        s_axis_tdata = 64'hBBBB_0002;
        s_axis_tkeep = 8'h0F;
        s_axis_tlast = 1'b1;
        #1;
        n_vec++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hAAAA_0001) begin
            n_err++;
            $display("FAIL bp_stall: ready=%b v=%b d=%h need 0 1 aaaa0001", s_axis_tready, m_axis_tvalid, m_axis_tdata);
        end
        @(posedge clk); #1;
        n_vec++;
        if (m_axis_tdata !== 64'hAAAA_0001 || m_axis_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: d=%h l=%b need aaaa0001 0", m_axis_tdata, m_axis_tlast);
        end
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        n_vec++;
        if (m_axis_tdata !== 64'hBBBB_0002 || m_axis_tkeep !== 8'h0F || m_axis_tlast !== 1'b1 ||
            m_axis_tuser !== 17'h0 || pend_count !== 4'd1) begin
            n_err++;
            $display("FAIL bp_release: d=%h k=%h l=%b u=%h pend=%0d need bbbb0002 0f 1 0 1",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, pend_count);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < PD; i++) single_frame(64'(i));
        s_axis_tdata  = 64'h9999;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        #1;
        n_vec++;
        if (s_axis_tready !== 1'b0) begin
            n_err++;
            $display("FAIL full_stall: ready=%b need 0", s_axis_tready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (m_axis_tvalid !== 1'b0 || pend_count !== 4'd8) begin
            n_err++;
            $display("FAIL full_hold: tvalid=%b pend=%0d need 0 8", m_axis_tvalid, pend_count);
        end
        s_ts_valid = 1'b1;
        s_ts_tag   = 16'd0;
        s_ts       = 96'h77;
        @(posedge clk); #1;
        s_ts_valid = 1'b0;
        n_vec++;
        if (s_axis_tready !== 1'b1 || m_ts_valid !== 1'b1 || m_ts_tag !== 16'd0 || pend_count !== 4'd7) begin
            n_err++;
            $display("FAIL full_pop: ready=%b tsv=%b tag=%0d pend=%0d need 1 1 0 7",
                     s_axis_tready, m_ts_valid, m_ts_tag, pend_count);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== {16'd8, 1'b0} || m_axis_tdata !== 64'h9999 || pend_count !== 4'd8) begin
            n_err++;
            $display("FAIL full_ninth: v=%b u=%h d=%h pend=%0d need 1 %h 9999 8",
                     m_axis_tvalid, m_axis_tuser, m_axis_tdata, pend_count, {16'd8, 1'b0});
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        single_frame(64'h1);
        single_frame(64'h2);
        s_ts_valid = 1'b1;
        s_ts_tag   = 16'd5;
        s_ts       = 96'h55;
        @(posedge clk); #1;
        n_vec++;
        if (stat_unexp !== 1'b1 || m_ts_valid !== 1'b0 || pend_count !== 4'd2) begin
            n_err++;
            $display("FAIL unexp_nomatch: unexp=%b tsv=%b pend=%0d need 1 0 2", stat_unexp, m_ts_valid, pend_count);
        end
        m_ts_ready = 1'b0;
        s_ts_tag   = 16'd0;
        s_ts       = 96'hAA;
        @(posedge clk); #1;
        n_vec++;
        if (stat_unexp !== 1'b0 || m_ts_valid !== 1'b1 || m_ts !== 96'hAA || pend_count !== 4'd1) begin
            n_err++;
            $display("FAIL unexp_first: unexp=%b tsv=%b ts=%h pend=%0d need 0 1 aa 1", stat_unexp, m_ts_valid, m_ts, pend_count);
        end
        s_ts_tag = 16'd1;
        s_ts     = 96'hBB;
        @(posedge clk); #1;
        s_ts_valid = 1'b0;
        n_vec++;
        if (stat_unexp !== 1'b1 || m_ts_valid !== 1'b1 || m_ts !== 96'hAA || m_ts_tag !== 16'd0 || pend_count !== 4'd0) begin
            n_err++;
            $display("FAIL unexp_busy: unexp=%b tsv=%b ts=%h tag=%0d pend=%0d need 1 1 aa 0 0",
                     stat_unexp, m_ts_valid, m_ts, m_ts_tag, pend_count);
        end
        @(posedge clk); #1;
        n_vec++;
        if (stat_unexp !== 1'b0 || m_ts_valid !== 1'b1 || m_ts !== 96'hAA) begin
            n_err++;
            $display("FAIL unexp_hold: unexp=%b tsv=%b ts=%h need 0 1 aa", stat_unexp, m_ts_valid, m_ts);
        end
        m_ts_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (m_ts_valid !== 1'b0) begin
            n_err++;
            $display("FAIL unexp_accept: tsv=%b need 0", m_ts_valid);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        single_frame(64'h10);
        s_axis_tdata  = 64'h11;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        s_ts_valid    = 1'b1;
        s_ts_tag      = 16'd0;
        s_ts          = 96'h123;
        @(posedge clk); #1;
        idle_inputs();
        n_vec++;
        if (pend_count !== 4'd1 || m_ts_tag !== 16'd0 || m_ts_valid !== 1'b1 || m_axis_tuser !== {16'd1, 1'b0}) begin
            n_err++;
            $display("FAIL pushpop: pend=%0d tag=%0d tsv=%b u=%h need 1 0 1 %h",
                     pend_count, m_ts_tag, m_ts_valid, m_axis_tuser, {16'd1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        single_frame(64'h20);
        s_axis_tdata  = 64'h21;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (pend_count !== 4'd0 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_clear: pend=%0d tvalid=%b need 0 0", pend_count, m_axis_tvalid);
        end
        single_frame(64'h22);
        n_vec++;
        if (m_axis_tuser !== 17'h0 || m_axis_tdata !== 64'h22 || pend_count !== 4'd1) begin
            n_err++;
            $display("FAIL midrst_tag: u=%h d=%h pend=%0d need 0 22 1", m_axis_tuser, m_axis_tdata, pend_count);
        end
    endtask

    task automatic test_tag_wrap();
        int unexp_seen = 0;
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            s_axis_tdata  = 64'(i);
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = 1'b1;
            s_axis_tvalid = 1'b1;
            s_ts_valid    = (i > 0);
            s_ts_tag      = 16'(i - 1);
            s_ts          = 96'(i - 1);
            @(posedge clk); #1;
            if (stat_unexp === 1'b1) unexp_seen++;
        end
        s_ts_valid = 1'b1;
        s_ts_tag   = 16'hFFFE;
        s_ts       = 96'hFFFE;
        @(posedge clk); #1;
        n_vec++;
        if (m_axis_tuser !== {16'hFFFF, 1'b0} || m_ts_tag !== 16'hFFFE || m_ts_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_ffff: u=%h tstag=%h tsv=%b need %h fffe 1", m_axis_tuser, m_ts_tag, m_ts_valid, {16'hFFFF, 1'b0});
        end
        s_ts_tag = 16'hFFFF;
        s_ts     = 96'hFFFF;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        n_vec++;
        if (m_axis_tuser !== 17'h0 || m_ts_tag !== 16'hFFFF) begin
            n_err++;
            $display("FAIL wrap_zero: u=%h tstag=%h need 0 ffff", m_axis_tuser, m_ts_tag);
        end
        s_ts_tag = 16'h0000;
        s_ts     = 96'h10000;
        @(posedge clk); #1;
        idle_inputs();
        if (stat_unexp === 1'b1) unexp_seen++;
        n_vec++;
        if (m_ts_tag !== 16'h0 || m_ts !== 96'h10000 || pend_count !== 4'd0 || unexp_seen !== 0) begin
            n_err++;
            $display("FAIL wrap_match: tstag=%h ts=%h pend=%0d unexp_pulses=%0d need 0 10000 0 0",
                     m_ts_tag, m_ts, pend_count, unexp_seen);
        end
    endtask

    task automatic test_timeout();
        int lost_at = 0;
        int lost_pulses = 0;
        do_reset();
        single_frame(64'h30);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (stat_lost === 1'b1) begin
                lost_pulses++;
                if (lost_at == 0) lost_at = k;
            end
        end
`ifdef ETH_MAC_TX_PTP_TAGGER_TIMEOUT_EN
        n_vec++;
        if (lost_at !== TO || lost_pulses !== 1 || pend_count !== 4'd0) begin
            n_err++;
            $display("FAIL timeout_lost: cycle=%0d pulses=%0d pend=%0d need %0d 1 0", lost_at, lost_pulses, pend_count, TO);
        end
`else
        n_vec++;
        if (lost_pulses !== 0 || pend_count !== 4'd1) begin
            n_err++;
            $display("FAIL no_timeout: lost_pulses=%0d pend=%0d need 0 1", lost_pulses, pend_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_tagging();
        test_match();
        test_backpressure();
        test_fifo_full();
        test_unexpected();
        test_push_pop();
        test_reset_mid_frame();
        test_timeout();
        test_tag_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
